// File: rtl/lfsr_unit.sv
// -----------------------------------------------------------------------------
// lfsr_unit
// 8-bit Fibonacci LFSR execution unit driven by the command strobes of the
// prpg control core. It holds the generator state, the tap mask and a data
// memory base address. A run command steps the LFSR N times on its own and
// streams every new value into data memory, holding busy so that prpg stalls.
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high reset
//   operand    in   8  seed / tap mask / base address / run count
//   lfsr_seed  in   1  load the LFSR state from operand (0 loads 8'h01)
//   lfsr_tap   in   1  load the tap mask from operand
//   lfsr_lmem  in   1  load the memory base address from operand
//   lfsr_run   in   1  start a run of operand steps
//   busy       out  1  high while running or signalling completion
//   done       out  1  one-cycle completion pulse
//   mem_wr     out  1  data-memory write enable
//   mem_addr   out  8  data-memory write address (0 when not writing)
//   mem_wd     out  8  data-memory write data (0 when not writing)
//   state      out  8  current LFSR state
// -----------------------------------------------------------------------------
module lfsr_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] operand,
    input  logic       lfsr_seed,
    input  logic       lfsr_tap,
    input  logic       lfsr_lmem,
    input  logic       lfsr_run,
    output logic       busy,
    output logic       done,
    output logic       mem_wr,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wd,
    output logic [7:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    localparam logic [7:0] LFSR_RST = 8'h01;
    localparam logic [7:0] TAPS_RST = 8'hB8;
    localparam logic [7:0] BASE_RST = 8'h00;

    // Fibonacci step: feedback is the parity of the tapped bits, shifted in at bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur, input logic [7:0] mask);
        return {cur[6:0], ^(cur & mask)};
    endfunction

    fsm_t       fsm_r,   fsm_nxt_s;
    logic [7:0] lfsr_r,  lfsr_nxt_s;
    logic [7:0] taps_r,  taps_nxt_s;
    logic [7:0] base_r,  base_nxt_s;
    logic [7:0] count_r, count_nxt_s;
    logic [7:0] idx_r,   idx_nxt_s;
    logic [7:0] step_s;
    logic       last_s;

    assign step_s = lfsr_step(lfsr_r, taps_r);
    // count_r is never 0 while in RUN, so count_r - 1 does not underflow there.
    assign last_s = (idx_r == (count_r - 8'd1));

    // Next-state and register-load decode; commands only act in IDLE, highest priority wins.
    always_comb begin
        fsm_nxt_s   = fsm_r;
        lfsr_nxt_s  = lfsr_r;
        taps_nxt_s  = taps_r;
        base_nxt_s  = base_r;
        count_nxt_s = count_r;
        idx_nxt_s   = idx_r;
        case (fsm_r)
            ST_IDLE: begin
                if (lfsr_seed) begin
                    // A zero seed would lock the LFSR at 0 forever.
                    if (operand == 8'h00) begin
                        lfsr_nxt_s = LFSR_RST;
                    end else begin
                        lfsr_nxt_s = operand;
                    end
                end else if (lfsr_tap) begin
                    taps_nxt_s = operand;
                end else if (lfsr_lmem) begin
                    base_nxt_s = operand;
                end else if (lfsr_run) begin
                    count_nxt_s = operand;
                    idx_nxt_s   = 8'd0;
                    if (operand == 8'h00) begin
                        fsm_nxt_s = ST_DONE;
                    end else begin
                        fsm_nxt_s = ST_RUN;
                    end
                end else begin
                    fsm_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                lfsr_nxt_s = step_s;
                idx_nxt_s  = idx_r + 8'd1;
                if (last_s) begin
                    fsm_nxt_s = ST_DONE;
                end else begin
                    fsm_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                fsm_nxt_s = ST_IDLE;
            end
            default: begin
                fsm_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_r   <= ST_IDLE;
            lfsr_r  <= LFSR_RST;
            taps_r  <= TAPS_RST;
            base_r  <= BASE_RST;
            count_r <= 8'd0;
            idx_r   <= 8'd0;
        end else begin
            fsm_r   <= fsm_nxt_s;
            lfsr_r  <= lfsr_nxt_s;
            taps_r  <= taps_nxt_s;
            base_r  <= base_nxt_s;
            count_r <= count_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Output decode from registered state only; address and data are forced to 0 when idle.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = 8'h00;
        mem_wd   = 8'h00;
        case (fsm_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_RUN: begin
                busy     = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = base_r + idx_r;
                mem_wd   = step_s;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign state = lfsr_r;

endmodule

// File: doc/lfsr_unit.md
# lfsr_unit

8-bit Fibonacci LFSR execution unit sitting directly downstream of the `prpg` control core. It consumes the `lfsr_seed`, `lfsr_tap`, `lfsr_lmem` and `lfsr_run` command strobes decoded by `prpg`, together with an 8-bit operand. It holds the generator state, the tap mask and the memory base address. On a run command it autonomously steps the LFSR N times and streams each value into data memory, raising `busy` so `prpg` stalls its program counter.

## Interface
- No parameters; all datapaths are 8 bits.
- `clk`  in  1  single system clock, rising-edge.
- `reset`  in  1  synchronous, active-high.
- `operand`  in  8  command operand: seed, tap mask, base address or run count.
- `lfsr_seed`  in  1  load the state register from `operand`.
- `lfsr_tap`  in  1  load the tap mask from `operand`.
- `lfsr_lmem`  in  1  load the memory base address from `operand`.
- `lfsr_run`  in  1  start a run of `operand` steps.
- `busy`  out  1  high while in RUN or DONE; `prpg` must hold its PC while high.
- `done`  out  1  one-cycle pulse when a run completes.
- `mem_wr`  out  1  data-memory write enable.
- `mem_addr`  out  8  data-memory write address.
- `mem_wd`  out  8  data-memory write data.
- `state`  out  8  current LFSR state, for register readback.

## Operation
- Registers and reset values: `lfsr` = 8'h01, `taps` = 8'hB8, `base` = 8'h00, `count` = 0, `idx` = 0, FSM = IDLE. All outputs are 0 at reset, except `state`, which is 8'h01.
- Step function: `fb` = ^(`lfsr` & `taps`); `next` = {`lfsr`[6:0], `fb`}.
- Command priority when several strobes are high in one cycle: seed > tap > lmem > run. Only the highest-priority strobe takes effect.
- Commands are accepted only in IDLE. Strobes seen in RUN or DONE are ignored and have no side effects.
- Seed: `lfsr` <= `operand`. If `operand` is 8'h00, the unit loads 8'h01 instead, so the LFSR cannot lock up.
- Tap: `taps` <= `operand`. A zero mask is legal; with a zero mask the stream shifts out to 0x00.
- Lmem: `base` <= `operand`.
- Run: `count` <= `operand` and `idx` <= 0.
  - If `operand` != 0, the FSM goes to RUN.
  - If `operand` == 0, the FSM goes to DONE with no writes.
- FSM:
  - IDLE -> RUN on a run command with a nonzero count.
  - IDLE -> DONE on a run command with a zero count.
  - RUN: each cycle, `mem_wr` = 1, `mem_addr` = `base` + `idx` (mod 256), `mem_wd` = `next`. At the clock edge, `lfsr` <= `next` and `idx` <= `idx` + 1. When `idx` == `count` - 1, go to DONE.
  - DONE: `done` = 1 and `mem_wr` = 0, then go to IDLE.
- Address arithmetic is 8-bit and wraps: `base` 8'hFE with count 3 writes addresses FE, FF, 00.
- `taps` and `base` are preserved across runs. `lfsr` continues from its last value, so back-to-back runs form one continuous sequence.

## Timing
- Seed, tap and lmem commands take effect at the sampling edge. `state` shows the new seed in the following cycle.
- For a run command sampled at edge 0 with count N > 0:
  - Writes occupy cycles 1..N.
  - `done` is high in cycle N+1.
  - The unit is back in IDLE, able to accept a command, in cycle N+2.
- `busy` is high in cycles 1..N+1 and is combinational from the FSM state.
- For count 0: `done` and `busy` are high in cycle 1 only, with no writes.
- `mem_wr`, `mem_addr`, `mem_wd` and `done` are decoded from registered state, so they are glitch-free within a cycle. `mem_addr` and `mem_wd` are 0 when `mem_wr` = 0.
- Reset asserted mid-run: at the next edge all registers return to their reset values. `mem_wr`, `busy` and `done` are 0 from that cycle on, with no partial-write continuation. A command strobe in the same cycle as reset is ignored.

## Test plan
- Reset with no commands, then run 4 (base 0x00, default seed 0x01, taps 0xB8) -> writes 02, 04, 08, 11 at addresses 00..03; `done` pulses in cycle 5; `state` = 8'h11 afterwards.
- Seed 0x00 -> `state` reads 8'h01. Then seed 0x80, taps 0x80, run 2 -> writes 01, 02.
- Lmem 0xFE, run 3 -> write addresses FE, FF, 00; `busy` is high for exactly 4 cycles.
- Run 0 -> no `mem_wr`; `done` and `busy` are high for one cycle.
- Seed and run strobed together with operand 0x05 -> only the seed takes effect (`state` = 8'h05) and no run starts. A run strobe issued during an active run is ignored, and the write count stays at the original N.
- Reset asserted in cycle 2 of a run of 10 -> `mem_wr` is low from the next cycle; `state` = 8'h01, `taps` = 8'hB8, `base` = 8'h00, FSM in IDLE.
